// File: rtl/c128_mmu_cfg_pkg.sv
// Shared constants for the C128 MMU configuration controller: register offsets,
// reset values and the {ms1,ms0} PLA region encoding.
package c128_pkg;

  localparam logic [7:0]  MMU_PAGE   = 8'hD5;
  localparam logic [15:0] LCR_FIRST  = 16'hFF00;
  localparam logic [15:0] LCR_LAST   = 16'hFF04;

  localparam logic [7:0] OFS_CR   = 8'h00;
  localparam logic [7:0] OFS_PCRA = 8'h01;
  localparam logic [7:0] OFS_PCRB = 8'h02;
  localparam logic [7:0] OFS_PCRC = 8'h03;
  localparam logic [7:0] OFS_PCRD = 8'h04;
  localparam logic [7:0] OFS_MCR  = 8'h05;
  localparam logic [7:0] OFS_RCR  = 8'h06;
  localparam logic [7:0] OFS_P0L  = 8'h07;
  localparam logic [7:0] OFS_P0H  = 8'h08;
  localparam logic [7:0] OFS_P1L  = 8'h09;
  localparam logic [7:0] OFS_P1H  = 8'h0A;
  localparam logic [7:0] OFS_VER  = 8'h0B;

  localparam logic [7:0] VER_VALUE   = 8'h20;
  localparam logic [7:0] UNMAPPED_RD = 8'hFF;
  localparam logic [7:0] RST_REG     = 8'h00;
  localparam logic [7:0] RST_P1L     = 8'h01;

  typedef enum logic [1:0] {
    MS_SYSROM = 2'b00,
    MS_INTFN  = 2'b01,
    MS_EXTFN  = 2'b10,
    MS_RAM    = 2'b11
  } ms_sel_e;

  function automatic ms_sel_e region_sel(input logic [1:0] a_hi, input logic [7:0] cr);
    ms_sel_e sel;
    case (a_hi)
      2'b00:   sel = MS_RAM;
      2'b01:   sel = cr[1] ? MS_RAM : MS_SYSROM;
      2'b10:   sel = ms_sel_e'(cr[3:2]);
      default: sel = ms_sel_e'(cr[5:4]);
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/c128_mmu_cfg_if.sv
// CPU-side bus of the MMU configuration controller.
interface c128_mmu_cfg_if;
  logic        bus_stb;
  logic        rw;
  logic [15:0] a;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        dout_en;

  modport master (output bus_stb, rw, a, din, input dout, dout_en);
  modport slave  (input bus_stb, rw, a, din, output dout, dout_en);
endinterface

// File: rtl/c128_mmu_cfg_sync2.sv
// Two-flop synchronizer for an asynchronous board input.
module c128_mmu_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/c128_mmu_cfg.sv
// C128 MMU register file and PLA mode/bank/address-translation generator.
// Optional page relocation: define C128_MMU_PAGE_RELOC_EN.
module c128_mmu_cfg
  import c128_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  c128_mmu_cfg_if.slave bus,
  input  logic          game_in,
  input  logic          exrom_in,
  input  logic          c4080_in,
  output logic          ms0,
  output logic          ms1,
  output logic          ms2,
  output logic          ms3,
  output logic          z80en,
  output logic [1:0]    ram_bank,
  output logic [1:0]    vic_bank,
  output logic [15:0]   ta,
  output logic          fsdir
);

  logic game_s, exrom_s, c4080_s;

  c128_mmu_sync2 u_sync_game  (.clk(clk), .rst(rst), .d_i(game_in),  .q_o(game_s));
  c128_mmu_sync2 u_sync_exrom (.clk(clk), .rst(rst), .d_i(exrom_in), .q_o(exrom_s));
  c128_mmu_sync2 u_sync_c4080 (.clk(clk), .rst(rst), .d_i(c4080_in), .q_o(c4080_s));

  logic [7:0] cr_q, cr_d;
  logic [7:0] mcr_q, mcr_d;
  logic [7:0] rcr_q, rcr_d;
  logic [7:0] pcr_q [4];
  logic [7:0] pcr_d [4];
  logic [7:0] dout_q, dout_d;
  logic       dout_en_q, dout_en_d;

  logic       hit_mmu, hit_lcr, wr_stb, rd_stb;
  logic [7:0] ofs;
  logic [1:0] lcr_idx;
  logic [7:0] mcr_rd;
  logic [7:0] rdata;
  logic [7:0] p0l_v, p0h_v, p1l_v, p1h_v;

  // The $D5xx page disappears once CR[0] selects RAM/ROM there; the LCR mirror never does.
  assign hit_mmu = (bus.a[15:8] == MMU_PAGE) && !cr_q[0];
  assign hit_lcr = (bus.a >= LCR_FIRST) && (bus.a <= LCR_LAST);
  assign wr_stb  = bus.bus_stb && !bus.rw;
  assign rd_stb  = bus.bus_stb && bus.rw;
  assign ofs     = bus.a[7:0];
  assign lcr_idx = 2'(bus.a[2:0] - 3'd1);
  assign mcr_rd  = {c4080_s, mcr_q[6], exrom_s, game_s, mcr_q[3], 2'b11, mcr_q[0]};

  always_comb begin
    cr_d  = cr_q;
    mcr_d = mcr_q;
    rcr_d = rcr_q;
    pcr_d = pcr_q;
    if (wr_stb && hit_lcr) begin
      if (bus.a[2:0] == 3'd0) cr_d = bus.din;
      else                    cr_d = pcr_q[lcr_idx];
    end else if (wr_stb && hit_mmu) begin
      case (ofs)
        OFS_CR:   cr_d     = bus.din;
        OFS_PCRA: pcr_d[0] = bus.din;
        OFS_PCRB: pcr_d[1] = bus.din;
        OFS_PCRC: pcr_d[2] = bus.din;
        OFS_PCRD: pcr_d[3] = bus.din;
        OFS_MCR:  mcr_d    = bus.din;
        OFS_RCR:  rcr_d    = bus.din;
        default:  ;
      endcase
    end
  end

  always_comb begin
    rdata = UNMAPPED_RD;
    if (hit_lcr) begin
      if (bus.a[2:0] == 3'd0) rdata = cr_q;
      else                    rdata = pcr_q[lcr_idx];
    end else if (hit_mmu) begin
      case (ofs)
        OFS_CR:   rdata = cr_q;
        OFS_PCRA: rdata = pcr_q[0];
        OFS_PCRB: rdata = pcr_q[1];
        OFS_PCRC: rdata = pcr_q[2];
        OFS_PCRD: rdata = pcr_q[3];
        OFS_MCR:  rdata = mcr_rd;
        OFS_RCR:  rdata = rcr_q;
        OFS_P0L:  rdata = p0l_v;
        OFS_P0H:  rdata = p0h_v;
        OFS_P1L:  rdata = p1l_v;
        OFS_P1H:  rdata = p1h_v;
        OFS_VER:  rdata = VER_VALUE;
        default:  rdata = UNMAPPED_RD;
      endcase
    end
  end

  always_comb begin
    dout_d    = dout_q;
    dout_en_d = 1'b0;
    if (rd_stb && (hit_mmu || hit_lcr)) begin
      dout_d    = rdata;
      dout_en_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cr_q      <= RST_REG;
      mcr_q     <= RST_REG;
      rcr_q     <= RST_REG;
      dout_q    <= '0;
      dout_en_q <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) pcr_q[i] <= RST_REG;
    end else begin
      cr_q      <= cr_d;
      mcr_q     <= mcr_d;
      rcr_q     <= rcr_d;
      dout_q    <= dout_d;
      dout_en_q <= dout_en_d;
      pcr_q     <= pcr_d;
    end
  end

`ifdef C128_MMU_PAGE_RELOC_EN
  logic [7:0] p0l_q, p0l_d, p0h_q, p0h_d, p0h_pend_q, p0h_pend_d;
  logic [7:0] p1l_q, p1l_d, p1h_q, p1h_d, p1h_pend_q, p1h_pend_d;

  // High bytes wait in a pending register so the low-byte write moves the whole pointer at once.
  always_comb begin
    p0l_d      = p0l_q;
    p0h_d      = p0h_q;
    p0h_pend_d = p0h_pend_q;
    p1l_d      = p1l_q;
    p1h_d      = p1h_q;
    p1h_pend_d = p1h_pend_q;
    if (wr_stb && hit_mmu) begin
      case (ofs)
        OFS_P0L: begin p0l_d = bus.din; p0h_d = p0h_pend_q; end
        OFS_P0H: p0h_pend_d = bus.din;
        OFS_P1L: begin p1l_d = bus.din; p1h_d = p1h_pend_q; end
        OFS_P1H: p1h_pend_d = bus.din;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0l_q      <= RST_REG;
      p0h_q      <= RST_REG;
      p0h_pend_q <= RST_REG;
      p1l_q      <= RST_P1L;
      p1h_q      <= RST_REG;
      p1h_pend_q <= RST_REG;
    end else begin
      p0l_q      <= p0l_d;
      p0h_q      <= p0h_d;
      p0h_pend_q <= p0h_pend_d;
      p1l_q      <= p1l_d;
      p1h_q      <= p1h_d;
      p1h_pend_q <= p1h_pend_d;
    end
  end

  assign p0l_v = p0l_q;
  assign p0h_v = p0h_q;
  assign p1l_v = p1l_q;
  assign p1h_v = p1h_q;

  always_comb begin
    ta = bus.a;
    if (bus.a[15:8] == 8'h00)                          ta[15:8] = p0l_q;
    else if (bus.a[15:8] == 8'h01)                     ta[15:8] = p1l_q;
    else if ((bus.a[15:8] == p0l_q) && (p0l_q != 8'h00)) ta[15:8] = 8'h00;
    else if ((bus.a[15:8] == p1l_q) && (p1l_q != 8'h01)) ta[15:8] = 8'h01;
  end
`else
  assign p0l_v = RST_REG;
  assign p0h_v = RST_REG;
  assign p1l_v = RST_P1L;
  assign p1h_v = RST_REG;
  assign ta    = bus.a;
`endif

  ms_sel_e ms_sel;
  assign ms_sel       = region_sel(bus.a[15:14], cr_q);
  assign {ms1, ms0}   = ms_sel;
  assign ms2          = cr_q[0];
  assign ms3          = ~mcr_q[6];
  assign z80en        = mcr_q[0];
  assign fsdir        = mcr_q[3];
  assign ram_bank     = cr_q[7:6];
  assign vic_bank     = rcr_q[7:6];
  assign bus.dout     = dout_q;
  assign bus.dout_en  = dout_en_q;

endmodule

// File: tb/tb_c128_mmu_cfg.sv
// Scoreboard bench for c128_mmu_cfg: read expectations are queued when the
// strobe is driven and compared when dout/dout_en appear a cycle later.
module tb_c128_mmu_cfg;

`ifdef C128_MMU_PAGE_RELOC_EN
  localparam bit RELOC = 1'b1;
`else
  localparam bit RELOC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic game_in, exrom_in, c4080_in;
  logic ms0, ms1, ms2, ms3, z80en, fsdir;
  logic [1:0] ram_bank, vic_bank;
  logic [15:0] ta;

  always #5 clk = ~clk;

  c128_mmu_cfg_if bus ();

  c128_mmu_cfg dut (
    .clk(clk), .rst(rst), .bus(bus),
    .game_in(game_in), .exrom_in(exrom_in), .c4080_in(c4080_in),
    .ms0(ms0), .ms1(ms1), .ms2(ms2), .ms3(ms3), .z80en(z80en),
    .ram_bank(ram_bank), .vic_bank(vic_bank), .ta(ta), .fsdir(fsdir)
  );

  typedef struct {
    logic       en;
    logic [7:0] data;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic rd_seen;

  always @(posedge clk or posedge rst) begin
    if (rst) rd_seen <= 1'b0;
    else     rd_seen <= bus.bus_stb && bus.rw;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_seen) begin
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: read completed with no queued expectation");
        end else begin
          e = sb.pop_front();
          if (bus.dout_en !== e.en || (e.en && bus.dout !== e.data)) begin
            errors++;
            $display("FAIL %s: got dout_en=%b dout=%h, expected dout_en=%b dout=%h",
                     e.name, bus.dout_en, bus.dout, e.en, e.data);
          end
        end
      end else begin
        checks++;
        if (bus.dout_en !== 1'b0) begin
          errors++;
          $display("FAIL idle_dout_en: got %b, expected 0", bus.dout_en);
        end
      end
    end
  end

  task automatic bus_op(input logic rw, input logic [15:0] addr, input logic [7:0] data,
                        input logic exp_en, input logic [7:0] exp_data, input string name);
    exp_t e;
    @(negedge clk);
    bus.bus_stb = 1'b1;
    bus.rw      = rw;
    bus.a       = addr;
    bus.din     = data;
    if (rw) begin
      e.en = exp_en; e.data = exp_data; e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] data);
    bus_op(1'b0, addr, data, 1'b0, 8'h00, "write");
  endtask

  task automatic rd(input logic [15:0] addr, input logic en, input logic [7:0] data, input string name);
    bus_op(1'b1, addr, 8'h00, en, data, name);
  endtask

  task automatic idle(input logic [15:0] addr);
    @(negedge clk);
    bus.bus_stb = 1'b0;
    bus.rw      = 1'b1;
    bus.a       = addr;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    game_in = 1'b1; exrom_in = 1'b1; c4080_in = 1'b1;
    bus.bus_stb = 1'b0; bus.rw = 1'b1; bus.a = 16'h0000; bus.din = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({ms3, ms2, z80en, bus.dout_en, bus.dout} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_outputs: ms3=%b ms2=%b z80en=%b dout_en=%b dout=%h, expected 1 0 0 0 00",
               ms3, ms2, z80en, bus.dout_en, bus.dout);
    end
    @(negedge clk);
    rst = 1'b0;
    rd(16'hD500, 1'b1, 8'h00, "reset_cr");
    rd(16'hD509, 1'b1, 8'h01, "reset_p1l");
    rd(16'hD507, 1'b1, 8'h00, "reset_p0l");
    rd(16'hD50B, 1'b1, 8'h20, "ver");
    wr(16'hD50B, 8'h77);
    rd(16'hD50B, 1'b1, 8'h20, "ver_readonly");
    rd(16'hD50C, 1'b1, 8'hFF, "unmapped_d50c");
    rd(16'hD5FF, 1'b1, 8'hFF, "unmapped_d5ff");
    idle(16'hC000);
    checks++;
    if ({ms1, ms0, ram_bank, vic_bank} !== {2'b00, 2'b00, 2'b00}) begin
      errors++;
      $display("FAIL reset_ms_c000: ms=%b ram_bank=%b vic_bank=%b, expected 00 00 00",
               {ms1, ms0}, ram_bank, vic_bank);
    end
  endtask

  task automatic test_lcr();
    logic [15:0] addrs [4];
    logic [1:0]  exp_ms [4];
    wr(16'hD502, 8'h3E);
    wr(16'hFF02, 8'h00);
    rd(16'hFF00, 1'b1, 8'h3E, "lcr_cr_after_ff02");
    rd(16'hFF02, 1'b1, 8'h3E, "lcr_pcrb_read");
    idle(16'hC000);
    checks++;
    if ({ms1, ms0, ms2} !== 3'b110) begin
      errors++;
      $display("FAIL lcr_ms_c000: ms=%b ms2=%b, expected 11 0", {ms1, ms0}, ms2);
    end
    wr(16'hD501, 8'hC4);
    wr(16'hFF01, 8'hAA);
    rd(16'hD500, 1'b1, 8'hC4, "lcr_cr_after_ff01");
    addrs  = '{16'h1000, 16'h4000, 16'h8000, 16'hC000};
    exp_ms = '{2'b11, 2'b00, 2'b01, 2'b00};
    for (int i = 0; i < 4; i++) begin
      idle(addrs[i]);
      checks++;
      if ({ms1, ms0} !== exp_ms[i] || ram_bank !== 2'b11) begin
        errors++;
        $display("FAIL lcr_region_%0d: a=%h ms=%b ram_bank=%b, expected ms=%b ram_bank=11",
                 i, addrs[i], {ms1, ms0}, ram_bank, exp_ms[i]);
      end
    end
  endtask

  task automatic test_io_disable();
    wr(16'hFF00, 8'h01);
    idle(16'h0000);
    checks++;
    if (ms2 !== 1'b1) begin
      errors++;
      $display("FAIL io_ms2: got %b, expected 1", ms2);
    end
    rd(16'hD500, 1'b0, 8'h00, "io_off_d500");
    rd(16'hD50B, 1'b0, 8'h00, "io_off_d50b");
    wr(16'hD500, 8'h55);
    wr(16'hD506, 8'h77);
    rd(16'hFF00, 1'b1, 8'h01, "io_off_ff00");
    wr(16'hFF00, 8'h00);
    rd(16'hD506, 1'b1, 8'h00, "io_off_rcr_ignored");
    rd(16'hD500, 1'b1, 8'h00, "io_on_cr");
  endtask

  task automatic test_page_reloc();
    logic [15:0] av [6];
    logic [15:0] tv [6];
    wr(16'hD508, 8'h01);
    rd(16'hD508, 1'b1, 8'h00, "p0h_pending_hidden");
    wr(16'hD507, 8'h20);
    rd(16'hD507, 1'b1, RELOC ? 8'h20 : 8'h00, "p0l_commit");
    rd(16'hD508, 1'b1, RELOC ? 8'h01 : 8'h00, "p0h_commit");
    wr(16'hD50A, 8'h07);
    wr(16'hD509, 8'h33);
    rd(16'hD509, 1'b1, RELOC ? 8'h33 : 8'h01, "p1l_commit");
    rd(16'hD50A, 1'b1, RELOC ? 8'h07 : 8'h00, "p1h_commit");
    av = '{16'h0012, 16'h2034, 16'h0199, 16'h3377, 16'h3000, 16'h0155};
    tv = RELOC ? '{16'h2012, 16'h0034, 16'h3399, 16'h0177, 16'h3000, 16'h3355}
               : '{16'h0012, 16'h2034, 16'h0199, 16'h3377, 16'h3000, 16'h0155};
    for (int i = 0; i < 6; i++) begin
      idle(av[i]);
      checks++;
      if (ta !== tv[i]) begin
        errors++;
        $display("FAIL ta_xlate_%0d: a=%h ta=%h, expected %h", i, av[i], ta, tv[i]);
      end
    end
  endtask

  task automatic test_mcr_sync();
    wr(16'hD505, 8'h41);
    idle(16'h0000);
    checks++;
    if ({ms3, z80en} !== 2'b01) begin
      errors++;
      $display("FAIL mcr_modes: ms3=%b z80en=%b, expected 0 1", ms3, z80en);
    end
    rd(16'hD505, 1'b1, 8'hF7, "mcr_read_inputs_high");
    idle(16'h0000);
    game_in = 1'b0;
    rd(16'hD505, 1'b1, 8'hF7, "mcr_game_not_yet");
    rd(16'hD505, 1'b1, 8'hE7, "mcr_game_synced");
    idle(16'h0000);
    game_in = 1'b1;
    wr(16'hD505, 8'h00);
    idle(16'h0000);
    checks++;
    if ({ms3, z80en} !== 2'b10) begin
      errors++;
      $display("FAIL mcr_restore: ms3=%b z80en=%b, expected 1 0", ms3, z80en);
    end
  endtask

  task automatic test_back_to_back();
    rd(16'hD501, 1'b1, 8'hC4, "b2b_pcra");
    rd(16'hD502, 1'b1, 8'h3E, "b2b_pcrb");
    wr(16'hD506, 8'h80);
    rd(16'hD506, 1'b1, 8'h80, "b2b_rcr");
    wr(16'hD505, 8'h08);
    rd(16'hD505, 1'b1, 8'hBE, "b2b_mcr");
    idle(16'h0000);
    checks++;
    if ({vic_bank, fsdir} !== 3'b101) begin
      errors++;
      $display("FAIL b2b_outputs: vic_bank=%b fsdir=%b, expected 10 1", vic_bank, fsdir);
    end
  endtask

  task automatic test_reset_pending();
    wr(16'hD508, 8'h05);
    @(negedge clk);
    bus.bus_stb = 1'b1; bus.rw = 1'b0; bus.a = 16'hD506; bus.din = 8'hC0;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.dout_en, vic_bank, fsdir} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async: dout_en=%b vic_bank=%b fsdir=%b, expected 0 00 0",
               bus.dout_en, vic_bank, fsdir);
    end
    @(negedge clk);
    bus.bus_stb = 1'b0;
    rst = 1'b0;
    wr(16'hD507, 8'h40);
    rd(16'hD508, 1'b1, 8'h00, "pending_lost_p0h");
    rd(16'hD507, 1'b1, RELOC ? 8'h40 : 8'h00, "after_reset_p0l");
    rd(16'hD509, 1'b1, 8'h01, "after_reset_p1l");
    rd(16'hD506, 1'b1, 8'h00, "dropped_rcr_write");
    idle(16'h0012);
    checks++;
    if (ta !== (RELOC ? 16'h4012 : 16'h0012) || vic_bank !== 2'b00) begin
      errors++;
      $display("FAIL after_reset_ta: ta=%h vic_bank=%b, expected %h 00",
               ta, vic_bank, RELOC ? 16'h4012 : 16'h0012);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lcr();
    test_io_disable();
    test_page_reloc();
    test_mcr_sync();
    test_back_to_back();
    test_reset_pending();
    repeat (3) idle(16'h0000);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/c128_mmu_cfg.md
# c128_mmu_cfg

Memory-management configuration controller for the C128 glue logic: holds the MMU register file ($D500–$D50B, LCR mirror $FF00–$FF04) and turns the current configuration plus CPU address into the mode/select inputs of the address-decode PLA (`ms0`–`ms3`, `z80en`) and the bank/relocated-address outputs that feed the DRAM path. It sits between the CPU bus and the PLA. All configuration changes are sequenced on a single clock edge so the PLA never sees a half-updated mode.

## Interface
- No parameters.
- `clk` in 1: system clock; all state changes on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `bus_stb` in 1: one-cycle CPU access strobe (end of PHI2 data phase).
- `rw` in 1: 1 = read, 0 = write.
- `a` in 16: CPU address.
- `din` in 8: CPU write data.
- `dout` out 8: read data, registered.
- `dout_en` out 1: drive data bus; high exactly one cycle after a read strobe hitting an MMU address.
- `game_in`, `exrom_in`, `c4080_in` in 1 each: asynchronous board inputs (active low as on the connector).
- `ms0`, `ms1`, `ms2`, `ms3`, `z80en` out 1 each: PLA mode inputs.
- `ram_bank` out 2: CR[7:6].
- `vic_bank` out 2: RCR[7:6].
- `ta` out 16: translated address (page-0/1 relocation applied).
- `fsdir` out 1: MCR[3].

## Operation
- Decode (`io` = CR[0]==0 or `a`∈$FF00–$FF04): CR at $D500 (only when CR[0]==0) and $FF00; PCRA–D $D501–$D504; MCR $D505; RCR $D506; P0L/P0H/P1L/P1H $D507–$D50A; VER $D50B read-only $20; $D50C–$D5FF read $FF, writes ignored.
- LCR: a write to $FF01–$FF04 copies PCRA–D respectively into CR; written data discarded. Reads of $FF01–$FF04 return the corresponding PCR.
- Page pointers: write to P0H/P1H stores into a pending high register only; write to P0L/P1L commits pending high and written low atomically. Reads return committed values.
- MCR reads: bits [5:4] = synchronized `exrom_in`/`game_in`, bit7 = synchronized `c4080_in`, bits [2:1] read 1, others as written.
- Outputs: `ms3` = ~MCR[6]; `ms2` = CR[0]; `z80en` = MCR[0]. `{ms1,ms0}` by address region: $0000–$3FFF → 11; $4000–$7FFF → CR[1]?11:00; $8000–$BFFF → {CR[3],CR[2]}; $C000–$FFFF → {CR[5],CR[4]}. Encoding 00 system ROM, 01 internal function, 10 external function, 11 RAM.
- Translation: `a[15:8]`==$00 → `ta[15:8]`=P0L; ==$01 → P1L; ==P0L (P0L≠0) → $00; ==P1L (P1L≠1) → $01; else passthrough. `ta[7:0]` = `a[7:0]` always.
- Same-cycle `bus_stb` and register write: outputs reflect new value the following cycle.

## Timing
- Reset values: CR, PCRA–D, MCR, RCR, P0L, P0H, P1H = $00; P1L = $01; pending highs $00; `dout`=$00, `dout_en`=0; synchronizers cleared to 0. Thus `z80en`=0, `ms3`=1, `ms2`=0 at reset.
- Write latency: register updated on the `bus_stb` edge; `ms*`, `ram_bank`, `ta` change one cycle later (combinational from registers and `a`).
- Read latency: `dout`/`dout_en` valid cycle after `bus_stb`, held one cycle.
- Board inputs: two-flop synchronizer, 2-cycle latency to MCR readback.
- Reset asserted mid-access: access dropped, all state to reset values immediately; pending high lost.

## Configuration
- `C128_MMU_PAGE_RELOC_EN` defined: page pointers and translation as above.
- Undefined: P0/P1 registers not implemented; reads return reset values ($00,$00,$01,$00), writes ignored, `ta` = `a`.

## Structure
- Shared package `c128_pkg`: register offset constants, VER value $20, `{ms1,ms0}` encoding enum, reset-value constants.
- One sub-module: `c128_mmu_sync2` (two-flop synchronizer, async reset), instanced per board input.

## Test plan
- Reset → CR=$00, P1L=$01, `z80en`=0, `ms3`=1; read $D50B → `dout`=$20, `dout_en`=1 one cycle later.
- Write $D502=$3E, write $FF02 data $00 → CR=$3E; `a`=$C000 gives `{ms1,ms0}`=11, `ms2`=0.
- Write CR=$01 then read $D500 → $FF-path not taken: `dout_en`=0; read $FF00 → $01.
- Write P0H=$01 → P0 readback unchanged; write P0L=$20 → `a`=$0012 gives `ta`=$2012, `a`=$2034 gives `ta`=$0034.
- MCR write $41 → `ms3`=0, `z80en`=1; toggle `game_in` low → MCR[4] reads 0 after 2 cycles.
- Assert `rst` between P0H and P0L writes → P0L write afterward commits P0H=$00.
